// File: rtl/ram_stream_reader.sv
// Streams `length` consecutive words out of a 2-cycle-latency synchronous RAM.
// Reads are credit-limited so the 4-entry output FIFO can never overflow.
module ram_stream_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] ram_read_addr,
   input  logic [DATA_WIDTH-1:0] ram_data,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last
);

   localparam int DEPTH  = 4;
   localparam int STAGES = 2;
   localparam int CW     = ADDR_WIDTH + 1;
   localparam int PW     = $clog2(DEPTH);
   localparam int NW     = PW + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   typedef struct packed {
      logic                  last;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CW-1:0]         len_q, len_d;
   logic [CW-1:0]         issued_q, issued_d;
   logic [STAGES:0]       vld_pipe_q, vld_pipe_d;
   logic [STAGES:0]       last_pipe_q, last_pipe_d;
   entry_t                fifo_q [DEPTH];
   entry_t                fifo_d [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [NW-1:0]         count_q, count_d;
   logic                  done_q, done_d;

   logic                  push, pop, credit_ok;
   logic [NW-1:0]         inflight, net_count;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      issued_d    = issued_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fifo_d      = fifo_q;
      done_d      = 1'b0;
      vld_pipe_d  = {vld_pipe_q[STAGES-1:0], 1'b0};
      last_pipe_d = {last_pipe_q[STAGES-1:0], 1'b0};

      push = vld_pipe_q[STAGES];
      pop  = (count_q != '0) && m_ready;
      inflight = '0;
      for (int s = 0; s <= STAGES; s++) inflight = inflight + NW'(vld_pipe_q[s]);
      // Occupancy net of this cycle's pop keeps full throughput with m_ready=1.
      net_count = count_q - NW'(pop);
      credit_ok = (net_count + inflight) < NW'(DEPTH);

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (length == '0) begin
                  done_d = 1'b1;
               end else begin
                  addr_d         = base_addr;
                  len_d          = length;
                  issued_d       = CW'(1);
                  vld_pipe_d[0]  = 1'b1;
                  last_pipe_d[0] = (length == CW'(1));
                  state_d        = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (issued_q == len_q) begin
               state_d = DRAIN;
            end else if (credit_ok) begin
               addr_d         = addr_q + 1'b1;
               issued_d       = issued_q + 1'b1;
               vld_pipe_d[0]  = 1'b1;
               last_pipe_d[0] = ((issued_q + 1'b1) == len_q);
            end
         end
         DRAIN: begin
            if ((vld_pipe_q == '0) && (net_count == '0)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (push) begin
         fifo_d[wr_ptr_q] = '{last: last_pipe_q[STAGES], data: ram_data};
         wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + NW'(push) - NW'(pop);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         len_q       <= '0;
         issued_q    <= '0;
         vld_pipe_q  <= '0;
         last_pipe_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         done_q      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         issued_q    <= issued_d;
         vld_pipe_q  <= vld_pipe_d;
         last_pipe_q <= last_pipe_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         done_q      <= done_d;
         fifo_q      <= fifo_d;
      end
   end

   assign busy          = (state_q != IDLE);
   assign done          = done_q;
   assign ram_read_addr = addr_q;
   assign m_valid       = (count_q != '0);
   assign m_data        = fifo_q[rd_ptr_q].data;
   assign m_last        = fifo_q[rd_ptr_q].last;

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: word width of the RAM data and the output stream.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 12: RAM address width.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; the RAM read clock is tied to it.
REQ-004 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: command strobe, sampled only in IDLE.
REQ-006 The block SHALL have port base_addr, input, ADDR_WIDTH bits: first read address, sampled with start.
REQ-007 The block SHALL have port length, input, ADDR_WIDTH+1 bits: word count 0..2^ADDR_WIDTH, sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse at command completion.
REQ-010 The block SHALL have port ram_read_addr, output, ADDR_WIDTH bits: registered read address driven to the RAM.
REQ-011 The block SHALL have port ram_data, input, DATA_WIDTH bits: RAM read data, valid 2 cycles after the address is presented.
REQ-012 The block SHALL have port m_data, output, DATA_WIDTH bits: stream data.
REQ-013 The block SHALL have port m_valid, output, 1 bit: stream valid.
REQ-014 The block SHALL have port m_ready, input, 1 bit: stream ready from the consumer.
REQ-015 The block SHALL have port m_last, output, 1 bit: high with the final word of a command.

Function
REQ-016 The block SHALL implement FSM states IDLE, ISSUE, DRAIN.
REQ-017 IDLE with start=1 and length>0 SHALL latch base_addr/length and go to ISSUE.
REQ-018 IDLE with start=1 and length=0 SHALL stay in IDLE, emit no data, and pulse done in the next cycle.
REQ-019 start while not IDLE SHALL be ignored.
REQ-020 In ISSUE, one read SHALL be issued per cycle only if (fifo_count + inflight) < 4: ram_read_addr is updated to the next address and a 2-stage valid shift register tracks the in-flight read.
REQ-021 The first issued address SHALL equal base_addr; each subsequent address SHALL be +1 modulo 2^ADDR_WIDTH (0xFFF wraps to 0x000 at default width).
REQ-022 A read issued in cycle t SHALL capture ram_data at the end of cycle t+2 into a 4-entry FIFO together with a last flag (set on the length-th word).
REQ-023 After the length-th read is issued, the FSM SHALL go to DRAIN; DRAIN SHALL go to IDLE when inflight=0 and the FIFO is empty after the final transfer, with done pulsing in the first IDLE cycle.
REQ-024 m_valid SHALL equal FIFO not empty; m_data/m_last SHALL be the FIFO head; a word transfers when m_valid & m_ready.
REQ-025 m_data/m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-026 A simultaneous FIFO push and pop SHALL leave the count unchanged, with no loss or duplication.
REQ-027 The credit rule SHALL guarantee the FIFO never overflows, under any m_ready pattern.
REQ-028 With m_ready held at 1, throughput SHALL be 1 word/cycle.
REQ-029 Start-to-first-data latency SHALL be: start in cycle 0 -> ram_read_addr=base in cycle 1 -> m_valid first high in cycle 4.
REQ-030 The word counters SHALL be ADDR_WIDTH+1 bits so that length=2^ADDR_WIDTH completes correctly.

Reset
REQ-031 reset_n=0 at a clock edge SHALL force IDLE, clear the FIFO, in-flight tracking and counters, and set busy=0, done=0, m_valid=0, m_last=0, ram_read_addr=0, m_data=0.
REQ-032 A reset mid-command SHALL abort it without a done pulse; RAM data returning after reset SHALL be discarded.

Verification
REQ-033 Scenario: base=0x010, length=4, m_ready=1 -> words from 0x010..0x013 on cycles 4-7, m_last on cycle 7, done pulse on cycle 8.
REQ-034 Scenario: base=0xFFE, length=4 -> read order 0xFFE, 0xFFF, 0x000, 0x001.
REQ-035 Scenario: length=16, m_ready random 30% duty -> all 16 words in order, exactly one m_last, no overflow, data stable during stalls.
REQ-036 Scenario: length=0 -> no m_valid, done pulse 1 cycle after start, busy stays 0.
REQ-037 Scenario: start pulsed again while busy -> ignored, the original stream is unaffected.
REQ-038 Scenario: reset_n=0 during word 3 of 8 -> all outputs are at reset values the next cycle, no done; a new command afterwards is clean.
